// File: rtl/pipeline_scheduler.sv
// Task/result scheduler for an interleaved multi-slot solver pipeline.
// Loads tasks into idle slots, collects scores into a credit-guarded result FIFO.
module pipeline_scheduler #(
  parameter int NSLOT  = 8,
  parameter int RDEPTH = 8,
  parameter int WARMUP = 8
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iFLUSH,
  input  logic             iTASK_VALID,
  output logic             oTASK_READY,
  input  logic [63:0]      iTASK_PLAYER,
  input  logic [63:0]      iTASK_OPPONENT,
  input  logic [7:0]       iTASK_TAG,
  output logic             oRES_VALID,
  input  logic             iRES_READY,
  output logic [7:0]       oRES_SCORE,
  output logic [7:0]       oRES_TAG,
  output logic             oPL_ENABLE,
  output logic             oPL_VALID,
  output logic [63:0]      oPL_PLAYER,
  output logic [63:0]      oPL_OPPONENT,
  input  logic             iPL_SOLVED,
  input  logic [7:0]       iPL_RES,
  input  logic [2:0]       iPL_SLOT,
  output logic [NSLOT-1:0] oBUSY,
  output logic [31:0]      oDONE_CNT,
  output logic [1:0]       oDBG_STATE
);

  localparam int CNT_W = $clog2(RDEPTH + 1);
  localparam int PTR_W = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int SUM_W = $clog2(NSLOT + RDEPTH + 1);
  localparam int WCW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {S_OFF, S_WARM, S_RUN, S_FLUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WCW-1:0]          r_wcnt;
  logic                    w_wcnt_clr, w_wdone;
  logic [NSLOT-1:0]        r_busy;
  logic [7:0]              r_tag [NSLOT];
  logic [15:0]             r_fifo [RDEPTH];
  logic [PTR_W-1:0]        r_wptr, r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic [31:0]             r_done_cnt;
  logic [SUM_W-1:0]        w_used;
  logic                    w_slot_busy, w_load, w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes: a task moves when iTASK_VALID & oTASK_READY (and no flush);
  // a result moves when oRES_VALID & iRES_READY. Neither side may retract.
  assign w_wdone = (r_wcnt == WCW'(WARMUP - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_clr  = 1'b0;
    if (iFLUSH) begin
      w_state_nxt = S_FLUSH;
      w_wcnt_clr  = 1'b1;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_WARM;
          w_wcnt_clr  = 1'b1;
        end
        S_WARM: if (w_wdone) w_state_nxt = S_RUN;
        S_FLUSH: if (w_wdone) begin
          w_state_nxt = S_WARM;
          w_wcnt_clr  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= S_OFF;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_clr ? '0 : r_wcnt + 1'b1;
    end
  end

  // Busy solvers plus queued results must never exceed FIFO capacity.
  always_comb begin
    w_used = SUM_W'(r_count);
    for (int i = 0; i < NSLOT; i++) w_used = w_used + SUM_W'(r_busy[i]);
  end

  assign w_slot_busy = r_busy[iPL_SLOT];
  assign oTASK_READY = (r_state == S_RUN) && !w_slot_busy && !iPL_SOLVED
                       && (w_used < SUM_W'(RDEPTH));
  assign w_load = iTASK_VALID & oTASK_READY & ~iFLUSH;
  assign w_push = (r_state == S_RUN) & iPL_SOLVED & w_slot_busy & ~iFLUSH;
  assign w_pop  = oRES_VALID & iRES_READY;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_busy <= '0;
      for (int i = 0; i < NSLOT; i++) r_tag[i] <= '0;
    end else if (iFLUSH) begin
      r_busy <= '0;
    end else begin
      if (w_push) r_busy[iPL_SLOT] <= 1'b0;
      if (w_load) begin
        r_busy[iPL_SLOT] <= 1'b1;
        r_tag[iPL_SLOT]  <= iTASK_TAG;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (iFLUSH) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push) r_fifo[r_wptr] <= {iPL_RES, r_tag[iPL_SLOT]};
  end

  // Completed-task count survives flushes; only reset clears it.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)   r_done_cnt <= '0;
    else if (w_pop) r_done_cnt <= r_done_cnt + 32'd1;
  end

  assign oRES_VALID   = (r_count != '0);
  assign oRES_SCORE   = oRES_VALID ? r_fifo[r_rptr][15:8] : 8'd0;
  assign oRES_TAG     = oRES_VALID ? r_fifo[r_rptr][7:0] : 8'd0;
  assign oPL_ENABLE   = (r_state == S_WARM) || (r_state == S_RUN);
  assign oPL_VALID    = w_load;
  assign oPL_PLAYER   = w_load ? iTASK_PLAYER : 64'd0;
  assign oPL_OPPONENT = w_load ? iTASK_OPPONENT : 64'd0;
  assign oBUSY        = r_busy;
  assign oDONE_CNT    = r_done_cnt;
  assign oDBG_STATE   = r_state;

  no_push_when_full: assert property (@(posedge iCLOCK) disable iff (!inRESET)
    !(w_push && !w_pop && (r_count == CNT_W'(RDEPTH))));

endmodule
